mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the shared memory port.
// master = requester/memory environment side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;

  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic [1:0]        d_req_fcn;
  logic [2:0]        d_req_typ;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_req_ready;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [1:0]        mem_req_fcn;
  logic [2:0]        mem_req_typ;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_fcn, d_req_typ, d_req_wdata,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_fcn, mem_req_typ, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_fcn, d_req_typ, d_req_wdata,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_fcn, mem_req_typ, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, REQ_HOLD, WAIT_RESP} state_t;

  state_t state, state_nxt;
  logic   owner_d;     // 1: data side owns the transaction, 0: fetch side
  logic   win_d;
  logic   sel_d;
  logic   req_active;
  logic   accept;
`ifdef MEM_ARB_RR_EN
  logic   last_d;      // side granted at the most recent accept
`endif

  always_comb begin
    win_d = bus.d_req_valid;
`ifdef MEM_ARB_RR_EN
    if (bus.d_req_valid && bus.i_req_valid)
      win_d = ~last_d;
`endif
  end

  // Once a request is presented the owner is locked until it is accepted.
  assign sel_d      = (state == IDLE) ? win_d : owner_d;
  assign req_active = ~reset & ((state == IDLE) ? (bus.i_req_valid | bus.d_req_valid)
                                                : (state == REQ_HOLD));
  assign accept     = req_active & bus.mem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_active)
        owner_d <= win_d;
`ifdef MEM_ARB_RR_EN
      if (accept)
        last_d <= sel_d;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_active) state_nxt = accept ? WAIT_RESP : REQ_HOLD;
      REQ_HOLD:  if (accept) state_nxt = WAIT_RESP;
      WAIT_RESP: if (bus.mem_resp_valid) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_fcn   = 2'd0;
    bus.mem_req_typ   = 3'd0;
    bus.mem_req_wdata = '0;
    bus.i_req_ready   = 1'b0;
    bus.d_req_ready   = 1'b0;
    bus.i_resp_valid  = 1'b0;
    bus.i_resp_data   = '0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_data   = '0;
    busy              = ~reset & (state != IDLE);

    if (req_active) begin
      bus.mem_req_valid = 1'b1;
      if (sel_d) begin
        bus.mem_req_addr  = bus.d_req_addr;
        bus.mem_req_fcn   = bus.d_req_fcn;
        bus.mem_req_typ   = bus.d_req_typ;
        bus.mem_req_wdata = bus.d_req_wdata;
        bus.d_req_ready   = bus.mem_req_ready;
      end else begin
        bus.mem_req_addr  = bus.i_req_addr;
        bus.mem_req_fcn   = 2'd0;
        bus.mem_req_typ   = 3'd3;
        bus.i_req_ready   = bus.mem_req_ready;
      end
    end

    // Responses outside WAIT_RESP are stray and dropped.
    if (~reset && state == WAIT_RESP && bus.mem_resp_valid) begin
      if (owner_d) begin
        bus.d_resp_valid = 1'b1;
        bus.d_resp_data  = bus.mem_resp_data;
      end else begin
        bus.i_resp_valid = 1'b1;
        bus.i_resp_data  = bus.mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, tie, hold, stray response and reset-abort cases.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; checks run 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.i_req_valid    = 1'b0;
    bus.i_req_addr     = '0;
    bus.d_req_valid    = 1'b0;
    bus.d_req_addr     = '0;
    bus.d_req_fcn      = 2'd0;
    bus.d_req_typ      = 3'd0;
    bus.d_req_wdata    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  initial begin
    logic exp_rr_fetch;
`ifdef MEM_ARB_RR_EN
    exp_rr_fetch = 1'b1;
`else
    exp_rr_fetch = 1'b0;
`endif
    clr_in();
    reset = 1'b1;

    // Reset: outputs held at 0 even with a request and ready present
    step();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_2000; bus.mem_req_ready = 1'b1;
    #1;
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_i_ready",   bus.i_req_ready,   0);
    chk("rst_busy",      busy,              0);

    // Fetch only
    step();
    reset = 1'b0;
    #1;
    chk("f_mem_valid", bus.mem_req_valid, 1);
    chk("f_mem_addr",  bus.mem_req_addr,  32'h0000_2000);
    chk("f_mem_fcn",   bus.mem_req_fcn,   0);
    chk("f_mem_typ",   bus.mem_req_typ,   3);
    chk("f_i_ready",   bus.i_req_ready,   1);
    chk("f_d_ready",   bus.d_req_ready,   0);
    step();
    clr_in();
    #1;
    chk("f_wait_busy",  busy,              1);
    chk("f_wait_valid", bus.mem_req_valid, 0);
    step();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEAD_BEEF;
    #1;
    chk("f_i_resp_valid", bus.i_resp_valid, 1);
    chk("f_i_resp_data",  bus.i_resp_data,  32'hDEAD_BEEF);
    chk("f_d_resp_valid", bus.d_resp_valid, 0);
    chk("f_d_resp_data",  bus.d_resp_data,  0);
    step();
    clr_in();
    #1;
    chk("f_after_i_resp", bus.i_resp_valid, 0);
    chk("f_after_busy",   busy,             0);

    // Tie: data write wins, fetch follows
    step();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_3000;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h0000_0100;
    bus.d_req_fcn = 2'd1; bus.d_req_typ = 3'd3; bus.d_req_wdata = 32'h55;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("t_mem_fcn",   bus.mem_req_fcn,   1);
    chk("t_mem_addr",  bus.mem_req_addr,  32'h0000_0100);
    chk("t_mem_wdata", bus.mem_req_wdata, 32'h55);
    chk("t_d_ready",   bus.d_req_ready,   1);
    chk("t_i_ready",   bus.i_req_ready,   0);
    step();
    bus.d_req_valid = 1'b0;
    #1;
    chk("t_wait_i_ready", bus.i_req_ready,   0);
    chk("t_wait_valid",   bus.mem_req_valid, 0);
    step();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0;
    #1;
    chk("t_d_resp_valid", bus.d_resp_valid, 1);
    chk("t_i_resp_valid", bus.i_resp_valid, 0);
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("t_f_addr",  bus.mem_req_addr, 32'h0000_3000);
    chk("t_f_ready", bus.i_req_ready,  1);
    step();
    bus.i_req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_1234;
    #1;
    chk("t_f_resp_valid", bus.i_resp_valid, 1);
    chk("t_f_resp_data",  bus.i_resp_data,  32'h0000_1234);

    // Data read alone, then a tie: round-robin grants fetch, fixed priority grants data
    step();
    clr_in();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h0000_0200; bus.d_req_typ = 3'd3;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("r_d_ready", bus.d_req_ready, 1);
    step();
    bus.d_req_valid = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_00AA;
    #1;
    chk("r_d_resp_data", bus.d_resp_data, 32'h0000_00AA);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_3004;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h0000_0204;
    #1;
    chk("r_tie_addr", bus.mem_req_addr, exp_rr_fetch ? 32'h0000_3004 : 32'h0000_0204);
    chk("r_tie_i_ready", bus.i_req_ready, exp_rr_fetch);
    chk("r_tie_d_ready", bus.d_req_ready, !exp_rr_fetch);
    step();
    clr_in();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0077;
    #1;
    chk("r_tie_i_resp", bus.i_resp_valid, exp_rr_fetch);
    chk("r_tie_d_resp", bus.d_resp_valid, !exp_rr_fetch);
    step();
    clr_in();

    // Hold: fetch stalled 3 cycles, data raised in cycle 2
    step();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_2004;
    #1;
    chk("h_c1_addr",  bus.mem_req_addr, 32'h0000_2004);
    chk("h_c1_ready", bus.i_req_ready,  0);
    step();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h0000_0400; bus.d_req_fcn = 2'd1;
    #1;
    chk("h_c2_busy",    busy,              1);
    chk("h_c2_addr",    bus.mem_req_addr,  32'h0000_2004);
    chk("h_c2_fcn",     bus.mem_req_fcn,   0);
    chk("h_c2_d_ready", bus.d_req_ready,   0);
    step();
    #1;
    chk("h_c3_addr", bus.mem_req_addr, 32'h0000_2004);
    step();
    bus.mem_req_ready = 1'b1;
    #1;
    chk("h_acc_addr",    bus.mem_req_addr, 32'h0000_2004);
    chk("h_acc_i_ready", bus.i_req_ready,  1);
    chk("h_acc_d_ready", bus.d_req_ready,  0);
    step();
    clr_in();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_C0DE;
    #1;
    chk("h_i_resp_valid", bus.i_resp_valid, 1);
    chk("h_i_resp_data",  bus.i_resp_data,  32'h0000_C0DE);
    chk("h_d_resp_valid", bus.d_resp_valid, 0);

    // Stray response in IDLE
    step();
    clr_in();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_AAAA;
    #1;
    chk("s_i_resp_valid", bus.i_resp_valid, 0);
    chk("s_d_resp_valid", bus.d_resp_valid, 0);
    chk("s_i_resp_data",  bus.i_resp_data,  0);
    chk("s_busy",         busy,             0);
    step();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("s_after_busy", busy, 0);

    // Reset in WAIT_RESP, late response discarded, next fetch completes
    step();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_5000; bus.mem_req_ready = 1'b1;
    #1;
    chk("x_i_ready", bus.i_req_ready, 1);
    step();
    clr_in();
    #1;
    chk("x_wait_busy", busy, 1);
    step();
    reset = 1'b1;
    #1;
    chk("x_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_BAD0;
    #1;
    chk("x_late_i_resp", bus.i_resp_valid, 0);
    chk("x_late_busy",   busy,             0);
    step();
    clr_in();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0000_6000; bus.mem_req_ready = 1'b1;
    #1;
    chk("x_new_addr",  bus.mem_req_addr, 32'h0000_6000);
    chk("x_new_ready", bus.i_req_ready,  1);
    step();
    clr_in();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1357_9BDF;
    #1;
    chk("x_new_resp_valid", bus.i_resp_valid, 1);
    chk("x_new_resp_data",  bus.i_resp_data,  32'h1357_9BDF);
    step();
    clr_in();
    #1;
    chk("x_end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
